// File: rtl/inst_rr_scheduler.sv
// Round-robin owner for one shared resource across the child instances of a root module.
// One-hot grants are held until done, a dropped request, or the hold-time limit.
module inst_rr_scheduler #(
  parameter int unsigned NUM_INST = 5,
  parameter int unsigned MAX_HOLD = 16,
  localparam int unsigned IDW = (NUM_INST > 1) ? $clog2(NUM_INST) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  input  logic [NUM_INST-1:0] req,
  input  logic [NUM_INST-1:0] done,
  output logic [NUM_INST-1:0] grant,
  output logic [IDW-1:0]      grant_id,
  output logic                busy,
  output logic                timeout_pulse,
  output logic [IDW-1:0]      timeout_id
);

  // Counter only needs to reach MAX_HOLD-1.
  localparam int unsigned HCW = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HCW-1:0] HoldLast = HCW'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);
  localparam logic [IDW-1:0] LastId = IDW'(NUM_INST - 1);

  typedef enum logic [0:0] {StIdle, StGrant} state_e;

  state_e              state_q, state_d;
  logic [IDW-1:0]      ptr_q, ptr_d;
  logic [HCW-1:0]      hold_cnt_q, hold_cnt_d;
  logic [NUM_INST-1:0] grant_q, grant_d;
  logic [IDW-1:0]      grant_id_q, grant_id_d;
  logic                busy_q, busy_d;
  logic                tpulse_q, tpulse_d;
  logic [IDW-1:0]      tid_q, tid_d;

  logic           win_found;
  logic [IDW-1:0] win_id;
  logic           own_done;
  logic           own_req;
  logic           hold_expired;
  logic           release_now;
  logic [IDW-1:0] ptr_after_owner;

  // Search starts at the pointer and wraps past NUM_INST-1 back to 0.
  always_comb begin
    int unsigned idx;
    win_found = 1'b0;
    win_id    = '0;
    idx       = 0;
    for (int unsigned i = 0; i < NUM_INST; i++) begin
      idx = (32'(ptr_q) + i) % NUM_INST;
      if (!win_found && req[idx[IDW-1:0]]) begin
        win_found = 1'b1;
        win_id    = idx[IDW-1:0];
      end
    end
  end

  assign own_done        = done[grant_id_q];
  assign own_req         = req[grant_id_q];
  assign hold_expired    = (MAX_HOLD != 0) && (hold_cnt_q == HoldLast);
  assign release_now     = own_done || !own_req || hold_expired;
  assign ptr_after_owner = (grant_id_q == LastId) ? '0 : grant_id_q + IDW'(1);

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    hold_cnt_d = hold_cnt_q;
    grant_d    = grant_q;
    grant_id_d = grant_id_q;
    busy_d     = busy_q;
    tpulse_d   = 1'b0;
    tid_d      = tid_q;

    unique case (state_q)
      StIdle: begin
        if (enable && win_found) begin
          state_d    = StGrant;
          grant_d    = NUM_INST'(1) << win_id;
          grant_id_d = win_id;
          busy_d     = 1'b1;
          hold_cnt_d = '0;
        end
      end
      StGrant: begin
        hold_cnt_d = hold_cnt_q + HCW'(1);
        if (release_now) begin
          state_d = StIdle;
          grant_d = '0;
          busy_d  = 1'b0;
          ptr_d   = ptr_after_owner;
          // A done or request drop in the final cycle wins over the timeout.
          if (!own_done && own_req) begin
            tpulse_d = 1'b1;
            tid_d    = grant_id_q;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      ptr_q      <= '0;
      hold_cnt_q <= '0;
      grant_q    <= '0;
      grant_id_q <= '0;
      busy_q     <= 1'b0;
      tpulse_q   <= 1'b0;
      tid_q      <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      hold_cnt_q <= hold_cnt_d;
      grant_q    <= grant_d;
      grant_id_q <= grant_id_d;
      busy_q     <= busy_d;
      tpulse_q   <= tpulse_d;
      tid_q      <= tid_d;
    end
  end

  assign grant         = grant_q;
  assign grant_id      = grant_id_q;
  assign busy          = busy_q;
  assign timeout_pulse = tpulse_q;
  assign timeout_id    = tid_q;

endmodule

// File: tb/tb_inst_rr_scheduler.sv
// Directed bench for inst_rr_scheduler: a cycle model checked on every falling edge,
// plus literal expectations at the key points of each scenario.
module tb_inst_rr_scheduler;

  localparam int N = 5;
  localparam int MAXH = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         enable = 1'b0;
  logic [N-1:0] req = '0;
  logic [N-1:0] done = '0;
  logic [N-1:0] grant;
  logic [2:0]   grant_id;
  logic         busy;
  logic         timeout_pulse;
  logic [2:0]   timeout_id;

  int checks = 0;
  int errors = 0;

  inst_rr_scheduler #(
    .NUM_INST(N),
    .MAX_HOLD(MAXH)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .req          (req),
    .done         (done),
    .grant        (grant),
    .grant_id     (grant_id),
    .busy         (busy),
    .timeout_pulse(timeout_pulse),
    .timeout_id   (timeout_id)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: who owns the resource, how long it has been visible, where the search starts.
  int m_busy, m_owner, m_ptr, m_held, m_gid, m_tp, m_tid;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy = 0; m_owner = 0; m_ptr = 0; m_held = 0; m_gid = 0; m_tp = 0; m_tid = 0;
    end else begin
      m_tp = 0;
      if (m_busy != 0) begin
        m_held++;
        if (done[m_owner] || !req[m_owner] || (MAXH != 0 && m_held == MAXH)) begin
          if (!done[m_owner] && req[m_owner]) begin
            m_tp  = 1;
            m_tid = m_owner;
          end
          m_busy = 0;
          m_ptr  = (m_owner + 1) % N;
        end
      end else if (enable && req != '0) begin
        int found;
        found = 0;
        for (int k = 0; k < N; k++) begin
          if (found == 0 && req[(m_ptr + k) % N]) begin
            found   = 1;
            m_owner = (m_ptr + k) % N;
          end
        end
        m_busy = 1;
        m_held = 0;
        m_gid  = m_owner;
      end
    end
  end

  always @(negedge clk) begin
    logic [N-1:0] exp_grant;
    exp_grant = '0;
    if (m_busy != 0) exp_grant[m_owner] = 1'b1;
    check("model_grant", 32'(grant), 32'(exp_grant));
    check("model_grant_id", 32'(grant_id), m_gid);
    check("model_busy", 32'(busy), m_busy);
    check("model_timeout_pulse", 32'(timeout_pulse), m_tp);
    check("model_timeout_id", 32'(timeout_id), m_tid);
  end

  task automatic reset_dut();
    @(negedge clk); #1;
    rst = 1'b1; req = '0; done = '0; enable = 1'b1;
    @(negedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic step();
    @(negedge clk); #1;
  endtask

  initial begin
    // Reset state
    #2;
    check("rst_grant", 32'(grant), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_grant_id", 32'(grant_id), 0);
    check("rst_timeout_id", 32'(timeout_id), 0);

    // Single requester, done after 3 grant cycles, pointer moves to 3
    reset_dut();
    req = 5'b00100;
    step();
    check("t1_grant", 32'(grant), 32'h04);
    check("t1_grant_id", 32'(grant_id), 2);
    check("t1_busy", 32'(busy), 1);
    step();
    step();
    done = 5'b00100;
    step();
    check("t1_release", 32'(grant), 0);
    check("t1_keep_id", 32'(grant_id), 2);
    done = '0;
    req  = 5'b01001;
    step();
    check("t1_ptr3_winner", 32'(grant), 32'h08);
    req = '0;
    step();
    check("t1_req_drop", 32'(grant), 0);

    // Fairness with every instance requesting
    reset_dut();
    req = 5'b11111;
    for (int k = 0; k < 6; k++) begin
      step();
      check("fair_grant_id", 32'(grant_id), k % N);
      check("fair_grant", 32'(grant), 32'(1) << (k % N));
      done = grant;
      step();
      check("fair_idle_gap", 32'(grant), 0);
      done = '0;
    end
    req = '0;

    // Timeout: grant visible exactly MAXH cycles, then a one-cycle pulse
    reset_dut();
    req = 5'b00010;
    for (int c = 0; c < MAXH; c++) begin
      step();
      check("to_held", 32'(grant), 32'h02);
      check("to_no_pulse", 32'(timeout_pulse), 0);
    end
    step();
    check("to_released", 32'(grant), 0);
    check("to_pulse", 32'(timeout_pulse), 1);
    check("to_id", 32'(timeout_id), 1);
    step();
    check("to_pulse_once", 32'(timeout_pulse), 0);
    check("to_regrant", 32'(grant), 32'h02);
    req = '0;
    step();
    check("to_drop_no_pulse", 32'(timeout_pulse), 0);

    // Race: done in the final grant cycle is a normal release
    reset_dut();
    req = 5'b00010;
    for (int c = 0; c < MAXH; c++) step();
    check("race_still_held", 32'(grant), 32'h02);
    done = 5'b00010;
    step();
    check("race_released", 32'(grant), 0);
    check("race_no_pulse", 32'(timeout_pulse), 0);
    check("race_tid", 32'(timeout_id), 0);
    done = '0;
    req  = '0;

    // Foreign done and enable
    reset_dut();
    req = 5'b01000;
    step();
    check("fe_grant", 32'(grant), 32'h08);
    done = 5'b00001;
    step();
    check("fe_foreign_done", 32'(grant), 32'h08);
    done   = '0;
    enable = 1'b0;
    step();
    check("fe_enable_low_hold", 32'(grant), 32'h08);
    done = 5'b01000;
    step();
    check("fe_release", 32'(grant), 0);
    done = '0;
    for (int c = 0; c < 3; c++) begin
      step();
      check("fe_blocked", 32'(grant), 0);
    end
    enable = 1'b1;
    req    = '0;

    // Asynchronous reset mid-grant
    reset_dut();
    req = 5'b10000;
    step();
    check("ar_grant", 32'(grant), 32'h10);
    #2;
    rst = 1'b1;
    #1;
    check("ar_async_grant", 32'(grant), 0);
    check("ar_async_busy", 32'(busy), 0);
    req = 5'b10001;
    @(negedge clk); #1;
    rst = 1'b0;
    step();
    check("ar_ptr0_winner", 32'(grant), 32'h01);
    req = '0;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/inst_rr_scheduler.md
Name: inst_rr_scheduler

Overview:
- Round-robin scheduler that shares one resource among the NUM_INST child instances of a generated root module (default 5, matching the five-instance fan-out).
- Grants are one-hot and held until the owner signals done, drops its request, or hits a hold-time limit.
- Sits beside the child instances in the root module; child request/done lines connect directly to it.

Parameters:
- NUM_INST, 5, number of requesters (≥2).
- MAX_HOLD, 16, maximum cycles one grant may stay asserted; 0 disables the timeout.
- IDW, $clog2(NUM_INST), width of grant_id and timeout_id (derived, not overridden).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- enable  input  1  allows new grants; an in-flight grant always completes.
- req  input  NUM_INST  per-instance request, level.
- done  input  NUM_INST  per-instance release pulse; only the granted bit is honoured.
- grant  output  NUM_INST  one-hot grant, all-zero when idle.
- grant_id  output  IDW  index of current or last granted instance.
- busy  output  1  high while any grant is asserted.
- timeout_pulse  output  1  one-cycle pulse on a forced release.
- timeout_id  output  IDW  index of the last forced-released instance.

Behaviour:
- Reset (async assert, sync release): grant=0, grant_id=0, busy=0, timeout_pulse=0, timeout_id=0, state=IDLE, rr pointer=0, hold_cnt=0.
- FSM states are IDLE and GRANT.
- IDLE → GRANT: at a rising edge with enable=1 and req≠0.
  - Winner is the first set req bit searching from pointer upward, wrapping NUM_INST-1 → 0.
  - grant, grant_id and busy are registered and become visible after that edge (1-cycle latency from a sampled request).
  - hold_cnt is cleared to 0.
- In GRANT, hold_cnt increments each cycle.
- Release condition (evaluated each GRANT cycle): done[grant_id]=1, or req[grant_id]=0, or (MAX_HOLD≠0 and hold_cnt==MAX_HOLD-1).
- On release, at that edge:
  - grant→0 and busy→0; state returns to IDLE.
  - pointer ← (grant_id+1) mod NUM_INST.
  - grant_id keeps its value.
- Release timing:
  - The grant is visible for exactly MAX_HOLD cycles at most.
  - At least one all-zero grant cycle always separates two consecutive grants.
- Forced release happens only when no done and no req drop occur in the final cycle.
  - On a forced release, timeout_pulse=1 for one cycle and timeout_id ← grant_id.
  - If done arrives in that same final cycle, it is a normal release: no pulse.
- done bits of non-granted instances are ignored in all states; done in IDLE is ignored.
- enable=0 in GRANT has no effect on the current grant; enable=0 in IDLE blocks new grants. Requests are not latched: they are re-sampled each cycle.
- Simultaneous release and new request by the same instance: that instance has the lowest priority at the next arbitration (pointer has moved past it).
- A req change by a non-granted instance during GRANT does not affect the current grant.
- rst asserted mid-grant: all outputs drop immediately (asynchronous); pointer returns to 0.

Test Plan:
- Single requester: after reset, req=5'b00100, enable=1 → grant=5'b00100 and grant_id=2 one edge later; pulse done[2] after 3 cycles → grant=0 next edge, pointer=3.
- Fairness: req=5'b11111 held, each owner pulses done after 1 cycle → grant order 0,1,2,3,4,0 with one idle cycle between grants.
- Timeout: MAX_HOLD=4, req=5'b00010 held, no done → grant visible exactly 4 cycles, then timeout_pulse=1 for one cycle, timeout_id=1, grant=0.
- Race: MAX_HOLD=4, done[1] in the 4th grant cycle → release with timeout_pulse=0.
- Foreign done and enable: grant on instance 3, pulse done[0] → no effect; drop enable mid-grant → grant holds until done[3]; afterwards no grant while enable=0 despite req=5'b01000.
- Reset mid-operation: rst high while grant=5'b10000 → grant=0, busy=0 without waiting for a clock edge; after release with req=5'b10001, winner is instance 0.
